// File: rtl/jk_counter_reg.sv
// WIDTH-bit JK register with up/down counting, clamped parallel load, modulo wrap and OVF/UNF pulses.
// Define JK_COUNTER_SAT_EN to make the counting modes saturate instead of wrap.
module jk_counter_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             SCLR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF,
  output logic             UNF
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_reg, q_next, jk_next;
  logic             ovf_reg, ovf_next, unf_reg, unf_next;
  logic             at_top, at_zero;

  assign at_top  = (q_reg >= MAX_COUNT);
  assign at_zero = (q_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_jk
      always_comb begin
        case ({J[gi], K[gi]})
          2'b10:   jk_next[gi] = 1'b1;
          2'b01:   jk_next[gi] = 1'b0;
          2'b11:   jk_next[gi] = ~q_reg[gi];
          default: jk_next[gi] = q_reg[gi];
        endcase
      end
    end
  endgenerate

  always_comb begin
    q_next   = q_reg;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (SCLR) begin
      q_next = '0;
    end else if (EN) begin
      case (MODE)
        MODE_JK: q_next = jk_next;
        MODE_UP: begin
          if (at_top) begin
`ifdef JK_COUNTER_SAT_EN
            q_next = MAX_COUNT;
`else
            q_next = '0;
`endif
            ovf_next = 1'b1;
          end else begin
            q_next = q_reg + ONE;
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
`ifdef JK_COUNTER_SAT_EN
            q_next = '0;
`else
            q_next = MAX_COUNT;
`endif
            unf_next = 1'b1;
          end else begin
            q_next = q_reg - ONE;
          end
        end
        default: q_next = (D > MAX_COUNT) ? MAX_COUNT : D;
      endcase
    end
  end

  // State changes on the falling edge; CLR_N clears without waiting for an edge.
  always_ff @(negedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  always_comb begin
    case (MODE)
      MODE_UP:   TC = at_top;
      MODE_DOWN: TC = at_zero;
      MODE_LOAD: TC = 1'b0;
      default:   TC = 1'b0;
    endcase
  end

  assign Q   = q_reg;
  assign OVF = ovf_reg;
  assign UNF = unf_reg;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Scoreboard bench for jk_counter_reg (WIDTH=8, MAX_COUNT=9); driver queues expectations, monitor checks them.
module tb_jk_counter_reg;

`ifdef JK_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] q;
    logic       ovf;
    logic       unf;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       sclr = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = '0, k = '0, d = '0;
  logic [7:0] q;
  logic       tc, ovf, unf;

  exp_t  sb_q[$];
  string sb_name[$];
  int    total = 0, passed = 0;
  bit    drive_done = 1'b0;

  jk_counter_reg #(.WIDTH(8), .MAX_COUNT(8'd9)) dut (
    .CLK(clk), .CLR_N(clr_n), .SCLR(sclr), .EN(en), .MODE(mode),
    .J(j), .K(k), .D(d), .Q(q), .TC(tc), .OVF(ovf), .UNF(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else
      passed++;
  endtask

  // Inputs change 1 time unit after the rising edge; the DUT samples on the next falling edge.
  task automatic step(input string nm, input bit s, input bit e, input logic [1:0] m,
                      input logic [7:0] ji, input logic [7:0] ki, input logic [7:0] di,
                      input logic [7:0] eq, input bit eo, input bit eu, input bit et);
    exp_t x;
    @(posedge clk); #1;
    sclr = s; en = e; mode = m; j = ji; k = ki; d = di;
    x.q = eq; x.ovf = eo; x.unf = eu; x.tc = et;
    sb_q.push_back(x);
    sb_name.push_back(nm);
    $display("drive %-12s sclr=%0d en=%0d mode=%b j=%h k=%h d=%h -> q=%h ovf=%0d unf=%0d tc=%0d",
             nm, s, e, m, ji, ki, di, eq, eo, eu, et);
  endtask

  // Monitor: each rising edge presents the result of the preceding falling edge.
  always @(posedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t  x;
      string nm;
      x  = sb_q.pop_front();
      nm = sb_name.pop_front();
      chk({nm, ".q"},   32'(q),   32'(x.q));
      chk({nm, ".ovf"}, 32'(ovf), 32'(x.ovf));
      chk({nm, ".unf"}, 32'(unf), 32'(x.unf));
      chk({nm, ".tc"},  32'(tc),  32'(x.tc));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.q", 32'(q), 32'h00);
    chk("rst.ovf", 32'(ovf), 32'h0);
    chk("rst.unf", 32'(unf), 32'h0);
    chk("rst.tc", 32'(tc), 32'h0);
    @(negedge clk); #1 clr_n = 1'b1;

    step("jk_5a", 0, 1, 2'b00, 8'h5A, 8'h00, 8'h00, 8'h5A, 0, 0, 0);
    @(posedge clk); #2;
    clr_n = 1'b0; en = 1'b0; mode = 2'b00;
    #1;
    chk("async.q", 32'(q), 32'h00);
    chk("async.ovf", 32'(ovf), 32'h0);
    chk("async.unf", 32'(unf), 32'h0);
    @(negedge clk); #1 clr_n = 1'b1;

    step("rel_up",  0, 1, 2'b01, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    step("jk_f0",   0, 1, 2'b00, 8'hF0, 8'h0F, 8'h00, 8'hF0, 0, 0, 0);
    step("jk_cf",   0, 1, 2'b00, 8'h0F, 8'h30, 8'h00, 8'hCF, 0, 0, 0);
    step("jk_tog",  0, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h30, 0, 0, 0);
    step("jk_hold", 0, 1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h30, 0, 0, 0);

    if (!SAT) begin
      step("ld8",     0, 1, 2'b11, 0, 0, 8'h08, 8'h08, 0, 0, 0);
      step("up9",     0, 1, 2'b01, 0, 0, 0, 8'h09, 0, 0, 1);
      step("upwrap",  0, 1, 2'b01, 0, 0, 0, 8'h00, 1, 0, 0);
      step("up1",     0, 1, 2'b01, 0, 0, 0, 8'h01, 0, 0, 0);
      step("dn0",     0, 1, 2'b10, 0, 0, 0, 8'h00, 0, 0, 1);
      step("dnwrap",  0, 1, 2'b10, 0, 0, 0, 8'h09, 0, 1, 0);
      step("ld_c8",   0, 1, 2'b11, 0, 0, 8'hC8, 8'h09, 0, 0, 0);
    end else begin
      step("ld9",     0, 1, 2'b11, 0, 0, 8'h09, 8'h09, 0, 0, 0);
      step("upsat1",  0, 1, 2'b01, 0, 0, 0, 8'h09, 1, 0, 1);
      step("upsat2",  0, 1, 2'b01, 0, 0, 0, 8'h09, 1, 0, 1);
      step("sclr",    1, 1, 2'b00, 0, 0, 0, 8'h00, 0, 0, 0);
      step("dnsat1",  0, 1, 2'b10, 0, 0, 0, 8'h00, 0, 1, 1);
      step("dnsat2",  0, 1, 2'b10, 0, 0, 0, 8'h00, 0, 1, 1);
      step("ld_c8",   0, 1, 2'b11, 0, 0, 8'hC8, 8'h09, 0, 0, 0);
    end

    step("en0_up",  0, 0, 2'b01, 0, 0, 0, 8'h09, 0, 0, 1);
    step("en0_jk",  0, 0, 2'b00, 0, 0, 0, 8'h09, 0, 0, 0);
    // Inputs active only around the rising edge must not disturb Q.
    @(negedge clk); #1;
    sclr = 1'b1; en = 1'b1; j = 8'hFF; k = 8'hFF;
    step("rise_only", 0, 0, 2'b00, 0, 0, 0, 8'h09, 0, 0, 0);
    step("sclr_en0",  1, 0, 2'b01, 0, 0, 0, 8'h00, 0, 0, 0);
    step("ld9b",      0, 1, 2'b11, 0, 0, 8'h09, 8'h09, 0, 0, 0);
    step("sclr_prio", 1, 1, 2'b01, 0, 0, 0, 8'h00, 0, 0, 0);
    step("ld9c",      0, 1, 2'b11, 0, 0, 8'h09, 8'h09, 0, 0, 0);
    step("up_ovf",    0, 1, 2'b01, 0, 0, 0, SAT ? 8'h09 : 8'h00, 1, 0, SAT);
    step("en0_clr",   0, 0, 2'b01, 0, 0, 0, SAT ? 8'h09 : 8'h00, 0, 0, SAT);
    step("jk_c8",     0, 1, 2'b00, 8'hC8, 8'h00, 0, SAT ? 8'hC9 : 8'hC8, 0, 0, 0);
    step("dn_big",    0, 1, 2'b10, 0, 0, 0, SAT ? 8'hC8 : 8'hC7, 0, 0, 0);
    step("up_big",    0, 1, 2'b01, 0, 0, 0, SAT ? 8'h09 : 8'h00, 1, 0, SAT);
    drive_done = 1'b1;
  end

  initial begin
    int waited;
    waited = 0;
    while (!drive_done && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (!drive_done || sb_q.size() != 0)
      $display("FAIL drain actual=%0d pending required=0 (done=%0d)", sb_q.size(), drive_done);
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jk_counter_reg.md
# jk_counter_reg

Parametrised WIDTH-bit register built from JK-flip-flop semantics, extended with synchronous up/down counting, parallel load, modulo wrap and overflow flagging. It is the general-purpose successor to the single-bit JK flip-flop and serves as the counter/state-register primitive for the lab datapath and sequencer designs. All state updates on the falling edge of CLK.

## Interface
- WIDTH, 8: register width in bits, 1..32.
- MAX_COUNT, 2**WIDTH-1: terminal value for counting modes, 1..2**WIDTH-1.

- CLK  in  1  clock; all state changes on negedge CLK.
- CLR_N  in  1  asynchronous active-low reset; Q, OVF, UNF cleared immediately while low.
- SCLR  in  1  synchronous clear; highest synchronous priority.
- EN  in  1  clock enable for MODE operations; SCLR ignores EN.
- MODE  in  2  00 JK, 01 count up, 10 count down, 11 load.
- J  in  WIDTH  per-bit J inputs (MODE 00).
- K  in  WIDTH  per-bit K inputs (MODE 00).
- D  in  WIDTH  parallel load data (MODE 11).
- Q  out  WIDTH  register contents.
- TC  out  1  combinational terminal count.
- OVF  out  1  registered one-cycle pulse: up-count wrapped.
- UNF  out  1  registered one-cycle pulse: down-count wrapped.

## Operation
- Reset: CLR_N low -> Q=0, OVF=0, UNF=0 asynchronously; release is sampled at the next falling edge.
- Priority per falling edge: SCLR (Q<=0, OVF<=0, UNF<=0), then EN=0 (Q holds, OVF<=0, UNF<=0), then MODE.
- MODE 00 JK, per bit i: J=0,K=0 hold; J=1,K=0 set; J=0,K=1 clear; J=1,K=1 toggle. No clamping; Q may exceed MAX_COUNT.
- MODE 01 up: Q>=MAX_COUNT -> Q<=0, OVF<=1; else Q<=Q+1.
- MODE 10 down: Q==0 -> Q<=MAX_COUNT, UNF<=1; else Q<=Q-1 (values above MAX_COUNT decrement normally).
- MODE 11 load: Q<=min(D, MAX_COUNT).
- OVF/UNF are 0 on every edge that does not produce the wrap.
- TC: MODE 01 -> (Q>=MAX_COUNT); MODE 10 -> (Q==0); MODE 00/11 -> 0. Not gated by EN.
- Arithmetic is WIDTH bits unsigned; no carry beyond WIDTH.

## Timing
- Latency: one falling edge from input sample to Q/OVF/UNF update.
- Inputs J, K, D, MODE, EN, SCLR must be stable around the falling edge; rising edge has no effect.
- TC valid combinationally after Q or MODE change; OVF high exactly for the period following the wrapping edge.
- CLR_N asserted mid-count: outputs clear without waiting for an edge; counting resumes from 0 on first falling edge after CLR_N high.
- SCLR and CLR_N simultaneous: CLR_N dominates (same result).
- MODE change between edges: next edge uses the new MODE; no internal state besides Q/OVF/UNF.

## Configuration
- JK_COUNTER_SAT_EN defined: counting modes saturate; up at Q>=MAX_COUNT sets Q<=MAX_COUNT and OVF<=1; down at Q==0 holds Q=0 and UNF<=1; OVF/UNF then remain asserted on every saturated edge.
- Undefined (default): wrap behaviour as in Operation; OVF/UNF are single-edge pulses per wrap.

## Test plan
- Reset: CLR_N=0 at arbitrary time with Q=0x5A -> Q=0x00, OVF=0, UNF=0 before next edge; release, MODE 01, EN=1 -> Q=1 after first falling edge.
- JK mode, WIDTH=8, Q=0xF0, J=0x0F, K=0x30, then J=K=0xFF -> Q=0xCF, then Q=0x30; J=K=0 -> Q holds.
- Up wrap, MAX_COUNT=9: load 8, count up 3 edges -> Q=9 (TC=1), 0 (OVF=1 one period), 1 (OVF=0).
- Down wrap, MAX_COUNT=9: Q=1, count down 2 edges -> Q=0 (TC=1), 9 (UNF=1); load D=0xC8 -> Q=9.
- Priority: EN=0 MODE 01 -> Q unchanged, OVF=0; SCLR=1 with EN=0 -> Q=0; rising-edge-only toggling of inputs -> no change.
- JK_COUNTER_SAT_EN build, MAX_COUNT=9: Q=9, count up 2 edges -> Q=9, OVF=1 both edges; Q=0 count down -> Q=0, UNF=1.
